uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ packet sources.
- Grants the transmitter to one requester per packet and accepts that requester's bytes one at a time.
- Drives the transmitter's data-valid/byte inputs and uses its done flag to pace each byte.
- Sits between the command/response sources and the single serial TX pin.

---
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ packet sources.
// Define UART_ARB_HEADER_EN to prefix every packet with header byte 8'hA0 | grant index.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DONE_TIMEOUT = 100000
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy,
  output logic                   o_Error
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [19:0] TO_LAST = 20'(DONE_TIMEOUT - 1);
`ifdef UART_ARB_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_SEND, S_WAIT_DONE, S_WAIT_REL} state_e;
  localparam state_e S_FIRST = S_HDR;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_DONE, S_WAIT_REL} state_e;
  localparam state_e S_FIRST = S_LOAD;
`endif
  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q, gidx_q, sel, nxt_ptr;
  logic [NUM_REQ-1:0] grant_q, ready_q;
  logic [7:0]         byte_q;
  logic [19:0]        cnt_q;
  logic               dv_q, last_q, busy_q, error_q, any_v;
  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction
  // Scan from the farthest offset down so the nearest valid requester at/after ptr wins.
  always_comb begin
    any_v = 1'b0;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (i_Req_Valid[wrap(int'(ptr_q) + i)]) begin
        any_v = 1'b1;
        sel = wrap(int'(ptr_q) + i);
      end
  end
  assign nxt_ptr = wrap(int'(gidx_q) + 1);
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= '0;
      dv_q    <= 1'b0;
      case (state_q)
        S_IDLE:
          if (any_v) begin
            grant_q <= NUM_REQ'(1) << sel;
            gidx_q  <= sel;
            busy_q  <= 1'b1;
            state_q <= S_FIRST;
          end
`ifdef UART_ARB_HEADER_EN
        S_HDR: begin
          byte_q  <= 8'hA0 | 8'(gidx_q);
          last_q  <= 1'b0;
          dv_q    <= 1'b1;
          state_q <= S_SEND;
        end
`endif
        S_LOAD:
          if (i_Req_Valid[gidx_q]) begin
            ready_q <= grant_q;
            byte_q  <= i_Req_Byte[{gidx_q, 3'b000} +: 8];
            last_q  <= i_Req_Last[gidx_q];
            dv_q    <= 1'b1;
            state_q <= S_SEND;
          end
        S_SEND: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE:
          if (i_Tx_Done) state_q <= S_WAIT_REL;
          else if (cnt_q + 20'd1 == TO_LAST) begin
            error_q <= 1'b1;
            grant_q <= '0;
            ptr_q   <= nxt_ptr;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else cnt_q <= cnt_q + 20'd1;
        S_WAIT_REL:
          if (!i_Tx_Done) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= nxt_ptr;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else state_q <= S_LOAD;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = busy_q;
  assign o_Error     = error_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven plus scoreboard bench for uart_tx_arbiter with a 20-cycle transmitter model.
module tb_uart_tx_arbiter;
  typedef struct {int sc; int k; logic [7:0] b; logic last; logic [3:0] eg;} vec_t;
  typedef struct {logic [7:0] b; logic [3:0] g;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        i_Reset = 1'b1;
  logic [3:0]  i_Req_Valid = '0, i_Req_Last = '0;
  logic [31:0] i_Req_Byte = '0;
  logic        i_Tx_Active = 1'b0, i_Tx_Done = 1'b0;
  logic [3:0]  o_Req_Ready, o_Grant;
  logic        o_Tx_DV, o_Busy, o_Error;
  logic [7:0]  o_Tx_Byte;
  uart_tx_arbiter #(.NUM_REQ(4), .DONE_TIMEOUT(64)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte),
    .i_Req_Last(i_Req_Last), .o_Req_Ready(o_Req_Ready), .o_Grant(o_Grant), .o_Tx_DV(o_Tx_DV),
    .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy),
    .o_Error(o_Error)
  );
  exp_t       sb[$];
  vec_t       tbl[16];
  logic [7:0] rb[4][32];
  logic       rl[4][32];
  logic [7:0] rbyte[4];
  int  len[4], pos[4], rdy_cnt[4];
  bit  open_pkt[4];
  int  tx_cnt = 0, done_cnt = 0, dv_cnt = 0, checks = 0, failures = 0;
  bit  tx_hang = 1'b0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic drive_reqs();
    for (int k = 0; k < 4; k++) begin
      i_Req_Valid[k] = pos[k] < len[k];
      rbyte[k] = '0;
      i_Req_Last[k] = 1'b0;
      if (pos[k] < len[k]) begin
        rbyte[k] = rb[k][pos[k]];
        i_Req_Last[k] = rl[k][pos[k]];
      end
    end
    i_Req_Byte = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
  endtask
  task automatic load(input int k, input logic [7:0] b, input logic last, input logic [3:0] g);
    if (pos[k] == len[k]) begin
      pos[k] = 0;
      len[k] = 0;
    end
`ifdef UART_ARB_HEADER_EN
    if (!open_pkt[k]) sb.push_back('{8'hA0 | 8'(k), g});
`endif
    sb.push_back('{b, g});
    rb[k][len[k]] = b;
    rl[k][len[k]] = last;
    len[k]++;
    open_pkt[k] = !last;
    drive_reqs();
  endtask
  task automatic flush();
    for (int k = 0; k < 4; k++) begin
      pos[k] = len[k];
      open_pkt[k] = 1'b0;
    end
    sb.delete();
    drive_reqs();
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (o_Tx_DV) begin
      dv_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL dv_unexpected actual byte=%0h expected no DV", o_Tx_Byte);
      end else begin
        checks--;
        e = sb.pop_front();
        check("tx_byte", o_Tx_Byte, e.b);
        check("tx_grant", o_Grant, e.g);
      end
    end
    if (o_Req_Ready != 4'b0) check("ready_in_grant", o_Req_Ready & ~o_Grant, 0);
    for (int k = 0; k < 4; k++)
      if (o_Req_Ready[k]) begin
        rdy_cnt[k]++;
        pos[k]++;
      end
    drive_reqs();
    if (o_Tx_DV) begin
      tx_cnt = 20;
      i_Tx_Active = 1'b1;
    end else if (tx_cnt > 0) begin
      if (!tx_hang) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_Tx_Active = 1'b0;
          i_Tx_Done = 1'b1;
          done_cnt = 2;
        end
      end
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) i_Tx_Done = 1'b0;
    end
  endtask
  function automatic bit drained();
    for (int k = 0; k < 4; k++) if (pos[k] != len[k]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(sb.size() == 0 && !o_Busy && drained()) && n < 3000) begin
      tick();
      n++;
    end
    check(nm, n < 3000, 1);
  endtask
  task automatic wait_dv(input string nm);
    int n = 0;
    while (!o_Tx_DV && n < 500) begin
      tick();
      n++;
    end
    check(nm, o_Tx_DV, 1);
  endtask
  task automatic clr_rdy();
    for (int k = 0; k < 4; k++) rdy_cnt[k] = 0;
  endtask
  task automatic do_reset();
    i_Reset = 1'b1;
    flush();
    repeat (3) tick();
    check("reset_outputs", {o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy, o_Error}, 0);
    i_Reset = 1'b0;
    tick();
  endtask
  initial begin
    int ecnt[4];
    int n;
    tbl = '{
      '{0, 1, 8'h11, 1'b0, 4'b0010}, '{0, 1, 8'h22, 1'b0, 4'b0010}, '{0, 1, 8'h33, 1'b1, 4'b0010},
      '{1, 2, 8'h24, 1'b1, 4'b0100}, '{1, 0, 8'h04, 1'b1, 4'b0001}, '{1, 1, 8'h14, 1'b1, 4'b0010},
      '{2, 0, 8'h00, 1'b1, 4'b0001}, '{2, 1, 8'h10, 1'b1, 4'b0010}, '{2, 2, 8'h20, 1'b1, 4'b0100},
      '{2, 3, 8'h30, 1'b1, 4'b1000}, '{2, 0, 8'h01, 1'b1, 4'b0001},
      '{3, 2, 8'h2F, 1'b1, 4'b0100},
      '{4, 3, 8'h5A, 1'b1, 4'b1000}, '{4, 0, 8'h0B, 1'b1, 4'b0001}, '{4, 1, 8'h1B, 1'b1, 4'b0010},
      '{4, 2, 8'h2B, 1'b1, 4'b0100}
    };
    for (int k = 0; k < 4; k++) begin
      len[k] = 0;
      pos[k] = 0;
      open_pkt[k] = 1'b0;
    end
    clr_rdy();
    for (int sc = 0; sc < 5; sc++) begin
      if (sc == 0 || sc == 2) do_reset();
      clr_rdy();
      for (int k = 0; k < 4; k++) ecnt[k] = 0;
      for (int r = 0; r < 16; r++)
        if (tbl[r].sc == sc) begin
          load(tbl[r].k, tbl[r].b, tbl[r].last, tbl[r].eg);
          ecnt[tbl[r].k]++;
        end
      wait_idle($sformatf("sc%0d_done", sc));
      check($sformatf("sc%0d_grant_idle", sc), o_Grant, 0);
      for (int k = 0; k < 4; k++) check($sformatf("sc%0d_ready_cnt%0d", sc, k), rdy_cnt[k], ecnt[k]);
    end
    // No preemption: req0 arrives while req2 is halfway through its packet.
    clr_rdy();
    for (int i = 0; i < 4; i++) load(2, 8'hC0 + 8'(i), i == 3, 4'b0100);
    n = 0;
    while (rdy_cnt[2] < 2 && n < 500) begin
      tick();
      n++;
    end
    check("nopre_mid", rdy_cnt[2], 2);
    load(0, 8'h0A, 1'b1, 4'b0001);
    wait_idle("nopre_done");
    check("nopre_ready2", rdy_cnt[2], 4);
    // Stall: requester 1 goes quiet for 50 cycles between bytes.
    clr_rdy();
    load(1, 8'h51, 1'b0, 4'b0010);
    n = 0;
    while (rdy_cnt[1] < 1 && n < 500) begin
      tick();
      n++;
    end
    repeat (40) tick();
    dv_cnt = 0;
    repeat (50) tick();
    check("stall_no_dv", dv_cnt, 0);
    check("stall_grant", o_Grant, 4'b0010);
    check("stall_busy", o_Busy, 1);
    check("stall_error", o_Error, 0);
    load(1, 8'h52, 1'b1, 4'b0010);
    wait_idle("stall_done");
    check("stall_ready1", rdy_cnt[1], 2);
    // Timeout: transmitter never reports done.
    tx_hang = 1'b1;
    load(3, 8'h77, 1'b1, 4'b1000);
    wait_dv("to_dv");
    repeat (63) tick();
    check("to_err_early", o_Error, 0);
    tick();
    check("to_err_set", o_Error, 1);
    check("to_grant_clr", o_Grant, 0);
    check("to_busy_clr", o_Busy, 0);
    flush();
    tx_hang = 1'b0;
    repeat (30) tick();
    load(0, 8'h08, 1'b1, 4'b0001);
    load(3, 8'h78, 1'b1, 4'b1000);
    wait_idle("to_ptr_done");
    check("to_err_sticky", o_Error, 1);
    // Asynchronous reset while waiting for done.
    load(2, 8'h98, 1'b1, 4'b0100);
    wait_idle("rst_pre_done");
    load(1, 8'h99, 1'b1, 4'b0010);
    wait_dv("rst_dv");
    repeat (3) tick();
    #2 i_Reset = 1'b1;
    #1 check("async_reset_outputs", {o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy, o_Error}, 0);
    flush();
    repeat (2) tick();
    i_Reset = 1'b0;
    repeat (30) tick();
    load(0, 8'h0C, 1'b1, 4'b0001);
    load(3, 8'h3C, 1'b1, 4'b1000);
    wait_idle("rst_ptr_done");
    check("rst_err_clear", o_Error, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
